// File: rtl/rom_msg_sequencer.sv
// Sequencer for the 8x12 display-message ROM: walks the 4 words of the bank chosen by a
// debounced sensor, holds each word for a programmable dwell and registers it to the displays.
module rom_msg_sequencer #(
   parameter int HOLD_CYCLES = 50000000,
   parameter int DEB_CYCLES  = 4,
   parameter int CNT_W       = 26
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic        EN,
   input  logic        SENSOR,
   input  logic [11:0] ROM_DATA,
   output logic [2:0]  ROM_ADDR,
   output logic        ROM_CS,
   output logic [11:0] DISP,
   output logic        DISP_VALID,
   output logic        BANK,
   output logic        WRAP
);

   localparam int SYNC_STAGES = 2;
   localparam int DEB_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
   localparam logic [DEB_W-1:0] DEB_LAST   = DEB_W'(DEB_CYCLES - 1);
   localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(HOLD_CYCLES - 1);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_FETCH = 2'd1,
      ST_HOLD  = 2'd2
   } state_t;

   state_t                 state_q, state_d;
   logic [SYNC_STAGES-1:0] sync_q, sync_d;
   logic                   s_sync;
   logic                   sensor_db_q, sensor_db_d;
   logic [DEB_W-1:0]       deb_cnt_q, deb_cnt_d;
   logic [CNT_W-1:0]       dwell_q, dwell_d;
   logic [1:0]             idx_q, idx_d;
   logic                   seq_bank_q, seq_bank_d;
   logic [11:0]            disp_q, disp_d;
   logic                   disp_valid_q, disp_valid_d;
   logic                   wrap_q, wrap_d;
   logic                   bank_change;
   logic                   dwell_done;

   // Two-flop synchronizer chain for the asynchronous sensor level.
   generate
      for (genvar gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
         if (gi == 0) begin : g_first
            assign sync_d[gi] = SENSOR;
         end else begin : g_next
            assign sync_d[gi] = sync_q[gi-1];
         end
      end
   endgenerate

   assign s_sync = sync_q[SYNC_STAGES-1];

   always_comb begin
      sensor_db_d = sensor_db_q;
      deb_cnt_d   = '0;
      if (s_sync != sensor_db_q) begin
         if (deb_cnt_q == DEB_LAST) begin
            sensor_db_d = s_sync;
         end else begin
            deb_cnt_d = deb_cnt_q + 1'b1;
         end
      end
   end

   // seq_bank_q is the bank the running sequence was started on; a mismatch restarts at word 0.
   assign bank_change = (sensor_db_q != seq_bank_q);
   assign dwell_done  = (dwell_q == DWELL_LAST);

   always_comb begin
      state_d      = state_q;
      idx_d        = idx_q;
      seq_bank_d   = seq_bank_q;
      dwell_d      = dwell_q;
      disp_d       = disp_q;
      disp_valid_d = disp_valid_q;
      wrap_d       = 1'b0;
      case (state_q)
         ST_IDLE: begin
            dwell_d = '0;
            if (EN) begin
               state_d    = ST_FETCH;
               idx_d      = 2'd0;
               seq_bank_d = sensor_db_q;
            end
         end
         ST_FETCH, ST_HOLD: begin
            if (!EN) begin
               state_d      = ST_IDLE;
               disp_valid_d = 1'b0;
               idx_d        = 2'd0;
               dwell_d      = '0;
            end else if (bank_change) begin
               state_d    = ST_FETCH;
               idx_d      = 2'd0;
               seq_bank_d = sensor_db_q;
               dwell_d    = '0;
            end else if (state_q == ST_FETCH) begin
               state_d      = ST_HOLD;
               disp_d       = ROM_DATA;
               disp_valid_d = 1'b1;
               dwell_d      = '0;
            end else if (dwell_done) begin
               state_d = ST_FETCH;
               idx_d   = idx_q + 2'd1;
               wrap_d  = (idx_q == 2'd3);
               dwell_d = '0;
            end else begin
               dwell_d = dwell_q + 1'b1;
            end
         end
         default: begin
            state_d      = ST_IDLE;
            idx_d        = 2'd0;
            dwell_d      = '0;
            disp_valid_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q      <= ST_IDLE;
         sync_q       <= '0;
         sensor_db_q  <= 1'b0;
         deb_cnt_q    <= '0;
         dwell_q      <= '0;
         idx_q        <= 2'd0;
         seq_bank_q   <= 1'b0;
         disp_q       <= 12'h000;
         disp_valid_q <= 1'b0;
         wrap_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         sync_q       <= sync_d;
         sensor_db_q  <= sensor_db_d;
         deb_cnt_q    <= deb_cnt_d;
         dwell_q      <= dwell_d;
         idx_q        <= idx_d;
         seq_bank_q   <= seq_bank_d;
         disp_q       <= disp_d;
         disp_valid_q <= disp_valid_d;
         wrap_q       <= wrap_d;
      end
   end

   assign ROM_CS     = (state_q == ST_FETCH);
   assign ROM_ADDR   = ROM_CS ? {sensor_db_q, idx_q} : 3'b000;
   assign DISP       = disp_q;
   assign DISP_VALID = disp_valid_q;
   assign BANK       = sensor_db_q;
   assign WRAP       = wrap_q;

endmodule
